// File: rtl/sha256core_out_collector_pkg.sv
// Shared constants, types and helpers for the sha256core result collector.
// Holds result geometry, slot indexing and the read-side FSM/beat types.
package sha256core_out_collector_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned N_WORDS   = 8;
  localparam int unsigned N_SLOTS   = 4;
  localparam int unsigned WCNT_W    = $clog2(N_WORDS);
  localparam int unsigned SLOT_W    = $clog2(N_SLOTS);
  localparam int unsigned ADDR_W    = SLOT_W + WCNT_W;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_OUT  = 1'b1
  } rd_state_e;

  // One beat on the downstream result stream.
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic              last;
    logic [WORD_W-1:0] data;
  } out_beat_t;

  // Buffer slot owned by a {seq_num, ctx_num} pair.
  function automatic logic [SLOT_W-1:0] slot_idx(input logic ctx_num, input logic seq_num);
    return {seq_num, ctx_num};
  endfunction

endpackage

// File: rtl/sha256_out_ram.sv
// Result buffer: 32 x 32 distributed RAM, one synchronous write port and
// one asynchronous read port. Contents are never cleared.
// Ports: CLK; we/waddr/wdata write port; raddr -> rdata_c (combinational).
module sha256_out_ram
  import sha256core_out_collector_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sha256core_out_collector.sv
// Receive-side collector for the sha256core result stream. Assembles the
// N_WORDS result words of each {seq,ctx} slot into a 4-slot buffer and
// streams complete results downstream, round-robin across full slots.
// Ports: CLK/RST_N (sync, active-low); core_dout* write side from the core;
// slot_free back-pressure to the scheduler; dout/dout_valid/dout_slot/
// dout_last + rd_en downstream handshake; err_overflow sticky error.
module sha256core_out_collector
  import sha256core_out_collector_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] core_dout,
  input  logic              core_dout_en,
  input  logic              core_dout_ctx_num,
  input  logic              core_dout_seq_num,
  output logic [N_SLOTS-1:0] slot_free,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] dout_slot,
  output logic              dout_last,
  input  logic              rd_en,
  output logic              err_overflow
);

  logic [SLOT_W-1:0] wr_slot_c;
  logic [WCNT_W-1:0] wcnt [N_SLOTS];
  logic [N_SLOTS-1:0] full;

  rd_state_e         state, state_n;
  out_beat_t         beat, beat_n;
  logic              valid_n;
  logic [WCNT_W-1:0] rptr, rptr_n;
  logic [SLOT_W-1:0] last_served, last_served_n;

  logic              pick_vld_c;
  logic [SLOT_W-1:0] pick_slot_c;
  logic              xfer_c;
  logic              rd_done_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [WORD_W-1:0] rdata_c;

  assign wr_slot_c = slot_idx(core_dout_ctx_num, core_dout_seq_num);
  assign xfer_c    = dout_valid & rd_en;

  assign dout      = beat.data;
  assign dout_slot = beat.slot;
  assign dout_last = beat.last;

  sha256_out_ram u_ram (
    .CLK     (CLK),
    .we      (core_dout_en),
    .waddr   ({wr_slot_c, wcnt[wr_slot_c]}),
    .wdata   (core_dout),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  // Write side: per-slot word counters, full flags, free flags, overflow.
  // The counter wraps to 0 on its own after word N_WORDS-1 (power of 2).
  // A write after a read completion in the same cycle wins on slot_free.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(N_SLOTS); i++) wcnt[i] <= '0;
      full         <= '0;
      slot_free    <= '1;
      err_overflow <= 1'b0;
    end else begin
      if (rd_done_c) begin
        full[beat.slot]      <= 1'b0;
        slot_free[beat.slot] <= 1'b1;
      end
      if (core_dout_en) begin
        wcnt[wr_slot_c]      <= WCNT_W'(wcnt[wr_slot_c] + 1'b1);
        slot_free[wr_slot_c] <= 1'b0;
        if (full[wr_slot_c]) err_overflow <= 1'b1;
        if (wcnt[wr_slot_c] == WCNT_W'(N_WORDS - 1)) full[wr_slot_c] <= 1'b1;
      end
    end
  end

  // Round-robin arbiter: first full slot after the last one served.
  always_comb begin
    pick_vld_c  = 1'b0;
    pick_slot_c = last_served;
    for (int unsigned i = 1; i <= N_SLOTS; i++) begin
      if (!pick_vld_c && full[last_served + SLOT_W'(i)]) begin
        pick_vld_c  = 1'b1;
        pick_slot_c = last_served + SLOT_W'(i);
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= RD_IDLE;
    else        state <= state_n;
  end

  // Read FSM next state.
  always_comb begin
    state_n = state;
    case (state)
      RD_IDLE: if (pick_vld_c) state_n = RD_OUT;
      RD_OUT:  if (xfer_c && beat.last) state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase
  end

  // Read FSM outputs: next beat, read pointer and RAM read address.
  always_comb begin
    beat_n        = beat;
    valid_n       = dout_valid;
    rptr_n        = rptr;
    last_served_n = last_served;
    rd_done_c     = 1'b0;
    raddr_c       = {beat.slot, rptr};
    case (state)
      RD_IDLE: begin
        raddr_c = {pick_slot_c, WCNT_W'(0)};
        if (pick_vld_c) begin
          beat_n.slot   = pick_slot_c;
          beat_n.data   = rdata_c;
          beat_n.last   = 1'b0;
          valid_n       = 1'b1;
          rptr_n        = WCNT_W'(1);
          last_served_n = pick_slot_c;
        end
      end
      RD_OUT: begin
        if (xfer_c) begin
          if (beat.last) begin
            valid_n     = 1'b0;
            beat_n.last = 1'b0;
            rd_done_c   = 1'b1;
          end else begin
            beat_n.data = rdata_c;
            beat_n.last = (rptr == WCNT_W'(N_WORDS - 1));
            rptr_n      = WCNT_W'(rptr + 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered read-side outputs; after reset arbitration starts at slot 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      beat        <= '0;
      dout_valid  <= 1'b0;
      rptr        <= '0;
      last_served <= SLOT_W'(N_SLOTS - 1);
    end else begin
      beat        <= beat_n;
      dout_valid  <= valid_n;
      rptr        <= rptr_n;
      last_served <= last_served_n;
    end
  end

endmodule
